// File: rtl/psg_pkg.sv
// Shared PSG definitions: level/sample types, encoder states and the
// non-linear volume table used by both the volume control and the meter.
package psg_pkg;

    typedef logic [3:0]  level_t;
    typedef logic [29:0] psg_sample_t;

    typedef enum logic {
        ENC_IDLE   = 1'b0,
        ENC_SEARCH = 1'b1
    } enc_state_t;

    localparam logic [7:0] VOL_TABLE [16] = '{
        8'd0,   8'd1,   8'd2,   8'd3,   8'd5,   8'd8,   8'd13,  8'd21,
        8'd34,  8'd55,  8'd89,  8'd121, 8'd151, 8'd185, 8'd220, 8'd255
    };

    // Amplitude threshold for level k; 255 << 21 still fits in 30 bits.
    function automatic psg_sample_t vol_threshold(input level_t k, input int unsigned shift);
        psg_sample_t gain;
        gain = psg_sample_t'(VOL_TABLE[k]);
        return gain << shift;
    endfunction

endpackage

// File: rtl/psg_level_encoder.sv
// Sequential threshold search: walks the volume table from the top entry
// down, one entry per cycle, and reports the first level whose threshold
// the peak reaches.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ENC_IDLE   | waiting for a window close (start)
//   ENC_SEARCH | comparing peak against threshold(k), k counting down
module psg_level_encoder
    import psg_pkg::*;
#(
    parameter int unsigned THR_SHIFT = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  psg_sample_t peak,
    output level_t      level,
    output logic        done
);

    enc_state_t state_q, state_d;
    level_t     k_q, k_d;
    level_t     level_d;
    logic       done_d;

    // State, search index and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENC_IDLE;
            k_q     <= '0;
            level   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            level   <= level_d;
            done    <= done_d;
        end
    end

    // Next-state: level 0 has threshold 0, so the k==0 exit is only a guard.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        level_d = level;
        done_d  = 1'b0;
        case (state_q)
            ENC_IDLE: begin
                if (start) begin
                    state_d = ENC_SEARCH;
                    k_d     = 4'd15;
                end
            end
            ENC_SEARCH: begin
                if ((peak >= vol_threshold(k_q, THR_SHIFT)) || (k_q == 4'd0)) begin
                    level_d = k_q;
                    done_d  = 1'b1;
                    state_d = ENC_IDLE;
                end else begin
                    k_d = k_q - 4'd1;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

endmodule

// File: rtl/psg_level_meter.sv
// Window peak meter for the scaled PSG channel output: tracks the peak over
// WINDOW valid samples, encodes it back to a 4-bit volume level, and keeps a
// decaying peak-hold level plus a sticky clip flag.
module psg_level_meter
    import psg_pkg::*;
#(
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned THR_SHIFT = 21,
    parameter int unsigned HOLD_WIN  = 8,
    parameter logic [29:0] CLIP_THR  = 30'h3FBFFC01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [29:0] i,
    input  logic        clr_i,
    output logic [3:0]  level_o,
    output logic        level_vld_o,
    output logic [3:0]  hold_o,
    output logic [29:0] peak_o,
    output logic        clip_o
);

    localparam int unsigned WCW = $clog2(WINDOW);
    localparam int unsigned HCW = (HOLD_WIN > 1) ? $clog2(HOLD_WIN) : 1;
    localparam logic [WCW-1:0] WIN_LAST  = WCW'(WINDOW - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_WIN - 1);

    // A full search takes 16 cycles and must finish before the next close.
    generate
        if (WINDOW < 17) begin : g_bad_window
            $error("psg_level_meter: WINDOW must be >= 17");
        end
        if (HOLD_WIN < 1) begin : g_bad_hold
            $error("psg_level_meter: HOLD_WIN must be >= 1");
        end
    endgenerate

    logic [WCW-1:0] win_cnt;
    psg_sample_t    run_pk;
    psg_sample_t    close_pk;
    logic           win_close;
    logic [HCW-1:0] hold_cnt;

    assign win_close = valid_i && (win_cnt == WIN_LAST);
    assign close_pk  = (i > run_pk) ? i : run_pk;

    // Window counter and running peak; the closing sample joins the closed window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_cnt <= '0;
            run_pk  <= '0;
            peak_o  <= '0;
        end else if (valid_i) begin
            if (win_close) begin
                peak_o  <= close_pk;
                run_pk  <= '0;
                win_cnt <= '0;
            end else begin
                run_pk  <= close_pk;
                win_cnt <= win_cnt + WCW'(1);
            end
        end
    end

    psg_level_encoder #(
        .THR_SHIFT (THR_SHIFT)
    ) u_encoder (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (win_close),
        .peak  (peak_o),
        .level (level_o),
        .done  (level_vld_o)
    );

    // Peak hold: jumps up at once, drops one step after HOLD_WIN quieter windows.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_o   <= '0;
            hold_cnt <= '0;
        end else if (level_vld_o) begin
            if (level_o >= hold_o) begin
                hold_o   <= level_o;
                hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
                hold_o   <= hold_o - 4'd1;
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + HCW'(1);
            end
        end
    end

    // Sticky clip flag; a clipping sample outranks a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clip_o <= 1'b0;
        end else if (valid_i && (i >= CLIP_THR)) begin
            clip_o <= 1'b1;
        end else if (clr_i) begin
            clip_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psg_level_meter.sv
// Randomized bench for psg_level_meter with a behavioural reference model:
// window peaks are tracked as plain maxima, levels come from a table scan and
// result timing is predicted from the close cycle.
module tb_psg_level_meter;

    localparam logic [29:0] CLIP = 30'h3FBFFC01;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [29:0] sample;
    logic        clr_i;
    logic [3:0]  level_o;
    logic        level_vld_o;
    logic [3:0]  hold_o;
    logic [29:0] peak_o;
    logic        clip_o;

    psg_level_meter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .i           (sample),
        .clr_i       (clr_i),
        .level_o     (level_o),
        .level_vld_o (level_vld_o),
        .hold_o      (hold_o),
        .peak_o      (peak_o),
        .clip_o      (clip_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    int vol [16] = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 121, 151, 185, 220, 255};

    // reference model state
    int          cyc       = 0;
    int          m_cnt     = 0;
    logic [29:0] m_pk      = '0;
    logic [29:0] exp_peak  = '0;
    int          exp_level = 0;
    int          due       = -1;
    int          peak_chk  = -1;
    int          hold_chk  = -1;
    int          m_hold    = 0;
    int          m_hcnt    = 0;
    bit          m_clip    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        else
            n_pass++;
    endtask

    function automatic int level_of(input logic [29:0] p);
        for (int k = 15; k >= 0; k--)
            if (longint'(p) >= (longint'(vol[k]) << 21)) return k;
        return 0;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pk = '0; due = -1; peak_chk = -1; hold_chk = -1;
        m_hold = 0; m_hcnt = 0; m_clip = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(level_o), 0);
        check({tag, "_vld"},   32'(level_vld_o), 0);
        check({tag, "_hold"},  32'(hold_o), 0);
        check({tag, "_peak"},  32'(peak_o), 0);
        check({tag, "_clip"},  32'(clip_o), 0);
    endtask

    // one clock: drive, advance model at the edge, then compare outputs
    task automatic step(input bit v, input logic [29:0] s, input bit c);
        int t;
        valid_i = v; sample = s; clr_i = c;
        @(posedge clk_i);
        t = cyc;
        if (v) begin
            if (s > m_pk) m_pk = s;
            if (m_cnt == 255) begin
                exp_peak  = m_pk;
                exp_level = level_of(m_pk);
                m_pk      = '0;
                m_cnt     = 0;
                peak_chk  = t + 1;
                due       = t + 2 + (15 - exp_level);
            end else begin
                m_cnt++;
            end
        end
        if (v && s >= CLIP) m_clip = 1'b1;
        else if (c)         m_clip = 1'b0;
        cyc++;
        #1;
        check("clip", 32'(clip_o), 32'(m_clip));
        if (cyc == peak_chk) check("peak", 32'(peak_o), 32'(exp_peak));
        if (cyc == due) begin
            check("vld", 32'(level_vld_o), 1);
            check("level", 32'(level_o), 32'(exp_level));
            if (exp_level >= m_hold) begin
                m_hold = exp_level; m_hcnt = 0;
            end else if (m_hcnt == 7) begin
                m_hold--; m_hcnt = 0;
            end else begin
                m_hcnt++;
            end
            hold_chk = cyc + 1;
            due = -1;
        end else if (level_vld_o) begin
            check("vld_spurious", 32'(level_vld_o), 0);
        end
        if (cyc == hold_chk) check("hold", 32'(hold_o), 32'(m_hold));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 30'($urandom()), 1'b0);
    endtask

    // 256 valid samples with peak pk at index pos, others strictly below pk
    task automatic window(input logic [29:0] pk, input int pos, input int gap, input bit rnd);
        logic [29:0] s;
        for (int n = 0; n < 256; n++) begin
            if (n == pos)     s = pk;
            else if (pk == 0) s = '0;
            else              s = 30'($urandom_range(0, 32'(pk) - 1));
            step(1'b1, s, rnd && ($urandom_range(0, 15) == 0));
            repeat (rnd ? $urandom_range(0, 2) : gap)
                step(1'b0, 30'($urandom()), rnd && ($urandom_range(0, 15) == 0));
        end
    endtask

    task automatic reset_now();
        valid_i = 1'b0; clr_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        cyc += 2;
        #1 rst_i = 1'b0;
    endtask

    initial begin
        logic [29:0] pk;
        rst_i = 1'b1; valid_i = 1'b0; sample = '0; clr_i = 1'b0;
        #12;
        check_all_zero("rst_init");
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // full scale: level 15 two cycles after the close
        window(30'h1FE00000, 0, 0, 1'b0);
        idle(20);
        // threshold boundaries between levels 6 and 5
        window(30'h01A00000, $urandom_range(0, 255), 0, 1'b0);
        idle(20);
        window(30'h019FFFFF, $urandom_range(0, 255), 0, 1'b0);
        idle(20);
        // peak carried only by the closing sample
        window(30'h10000000, 255, 0, 1'b0);
        idle(20);
        // silence with valid every third cycle
        window(30'h0, 0, 2, 1'b0);
        idle(20);

        // hold decay
        reset_now();
        window(30'h12E00000, $urandom_range(0, 255), 0, 1'b0);
        idle(20);
        for (int w = 0; w < 16; w++) begin
            window(30'h00600000, $urandom_range(0, 255), 0, 1'b0);
            if (w == 6) begin
                idle(20);
                check("hold_7win", 32'(hold_o), 12);
            end
        end
        idle(20);
        check("hold_16win", 32'(hold_o), 10);
        window(30'h17200000, $urandom_range(0, 255), 0, 1'b0);
        idle(20);
        check("hold_jump", 32'(hold_o), 13);

        // random windows with gaps, clears and occasional clipping peaks
        for (int w = 0; w < 5; w++) begin
            if ($urandom_range(0, 3) == 0)
                pk = CLIP + 30'($urandom_range(0, 32'h3FE));
            else
                pk = 30'($urandom()) >> $urandom_range(0, 29);
            window(pk, $urandom_range(0, 255), 0, 1'b1);
        end
        idle(20);

        // reset mid-window, then a normal window
        reset_now();
        for (int n = 0; n < 100; n++) step(1'b1, 30'($urandom()), 1'b0);
        reset_now();
        window(30'h0B200000, $urandom_range(0, 255), 0, 1'b0);
        idle(20);

        // reset mid-search (level 0 search is 16 cycles long)
        window(30'h0, 0, 0, 1'b0);
        idle(5);
        reset_now();
        idle(40);
        window(30'h01A00000, $urandom_range(0, 255), 0, 1'b0);
        idle(20);

        // clip set / clear priority
        reset_now();
        step(1'b1, CLIP, 1'b0);
        check("clip_set", 32'(clip_o), 1);
        step(1'b0, 30'h0, 1'b1);
        check("clip_clr", 32'(clip_o), 0);
        step(1'b1, CLIP, 1'b1);
        check("clip_set_wins", 32'(clip_o), 1);
        step(1'b0, 30'h0, 1'b1);
        step(1'b1, CLIP - 30'd1, 1'b0);
        check("clip_below", 32'(clip_o), 0);
        step(1'b0, CLIP, 1'b0);
        check("clip_invalid", 32'(clip_o), 0);
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
